seq_detect_param: RTL

- Parameterised serial bit-pattern detector. Generalises the fixed-pattern Mealy sequence detector to:
  - any pattern length and value;
  - selectable overlapping or non-overlapping matching;
  - an input-valid qualifier;
  - both a Mealy pulse and a registered one-cycle-late pulse;
  - a saturating match counter.
- Sits on a 1-bit serial stream in the fsms library. Used as a framing/sync-word detector.

---
 rtl/seq_detect_param_pkg.sv | 43 ++++
 rtl/seq_detect_param_next.sv | 45 ++++
 rtl/seq_detect_param.sv | 65 ++++++
 3 files changed

// File: rtl/seq_detect_param_pkg.sv
// Shared helpers for the parameterised serial pattern detector.
package seq_detect_param_pkg;

  localparam int unsigned MAX_PAT_W = 16;
  localparam int unsigned IDX_W     = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // True when the last k bits of h equal the first k bits of the pat_w-bit pattern.
  function automatic logic pre_suf_eq(input logic [MAX_PAT_W-1:0] pat,
                                      input int unsigned          pat_w,
                                      input logic [MAX_PAT_W-1:0] h,
                                      input int unsigned          k);
    logic eq;
    eq = 1'b1;
    for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
      if (i < k) begin
        if (h[IDX_W'(i)] != pat[IDX_W'(pat_w - k + i)]) eq = 1'b0;
      end
    end
    return eq;
  endfunction

  function automatic int unsigned border_len(input logic [MAX_PAT_W-1:0] pat,
                                             input int unsigned          pat_w);
    int unsigned b;
    b = 0;
    for (int unsigned k = 1; k < MAX_PAT_W; k++) begin
      if (k < pat_w) begin
        if (pre_suf_eq(pat, pat_w, pat, k)) b = k;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/seq_detect_param_next.sv
// Combinational next-state for the detector: (s, in) -> (next_s, hit), KMP-style fallback.
module seq_detect_next
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1011,
  parameter int unsigned         OVERLAP = 1,
  parameter int unsigned         SW      = 3
) (
  input  logic [SW-1:0] s,
  input  logic          in,
  output logic [SW-1:0] next_s_c,
  output logic          hit_c
);

  localparam logic [MAX_PAT_W-1:0] PAT16  = MAX_PAT_W'(PATTERN);
  localparam int unsigned          BORDER = border_len(PAT16, PAT_W);

  logic [MAX_PAT_W-1:0] h;

  always_comb begin
    h        = '0;
    hit_c    = 1'b0;
    next_s_c = '0;

    // h: the s matched pattern bits followed by the new bit in h[0]
    h[0] = in;
    for (int unsigned j = 1; j < MAX_PAT_W; j++) begin
      if (j <= 32'(s)) h[IDX_W'(j)] = PAT16[IDX_W'(PAT_W - 32'(s) - 1 + j)];
    end

    hit_c = (32'(s) == PAT_W - 1) && (in == PAT16[0]);

    if (hit_c) begin
      next_s_c = (OVERLAP != 0) ? SW'(BORDER) : '0;
    end else begin
      for (int unsigned k = 1; k < MAX_PAT_W; k++) begin
        if ((k <= 32'(s) + 1) && (k < PAT_W)) begin
          if (pre_suf_eq(PAT16, PAT_W, h, k)) next_s_c = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial bit-pattern detector: Mealy match, registered match, saturating count.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int unsigned      OVERLAP = 1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  output logic             out,
  output logic             out_reg,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned SW = clog2(PAT_W + 1);

  logic [SW-1:0]    s_q, s_d, next_s;
  logic             out_reg_q, out_reg_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic             hit;

  seq_detect_next #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_next (
    .s        (s_q),
    .in       (in),
    .next_s_c (next_s),
    .hit_c    (hit)
  );

  always_comb begin
    out           = 1'b0;
    s_d           = s_q;
    match_count_d = match_count_q;
    out_reg_d     = 1'b0;

    if (reset) begin
      s_d           = '0;
      match_count_d = '0;
    end else if (en) begin
      out       = hit;
      out_reg_d = hit;
      s_d       = next_s;
      // Saturate rather than wrap
      if (hit && (match_count_q != '1)) match_count_d = match_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    s_q           <= s_d;
    out_reg_q     <= out_reg_d;
    match_count_q <= match_count_d;
  end

  assign out_reg     = out_reg_q;
  assign match_count = match_count_q;

endmodule
